dmem_responder: RTL

- Data-memory responder on the far side of the processor's MEM-stage load/store interface.
- Accepts one word request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs the read or write on its own 32-bit word-addressed array.
- Returns read data plus an error flag on a separate valid/ready response channel.

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request at a time, waits WAIT_CYCLES,
// then performs the load/store on a local array and answers on a valid/ready channel.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       txn_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q;
  logic [3:0]          wait_cnt_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [15:0]         txn_count_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                go_resp;
  logic                acc_we_d;
  logic [31:0]         acc_addr_d;
  logic [DATA_W-1:0]   acc_wdata_d;
  logic                in_range;
  logic [ADDR_W-1:0]   idx;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request inputs stand in for the not-yet-latched copies.
  always_comb begin
    acc_we_d    = we_q;
    acc_addr_d  = addr_q;
    acc_wdata_d = wdata_q;
    if (state_q == IDLE) begin
      acc_we_d    = req_we;
      acc_addr_d  = req_addr;
      acc_wdata_d = req_wdata;
    end
  end

  assign go_resp  = ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state_q == WAIT) && (wait_cnt_q == 4'd0));
  assign in_range = acc_addr_d < 32'(DEPTH);
  assign idx      = acc_addr_d[ADDR_W-1:0];

  always_ff @(posedge clk1) begin
    if (reset && go_resp && acc_we_d && in_range) begin
      mem_q[idx] <= acc_wdata_d;
    end
  end

  always_ff @(posedge clk1) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      txn_count_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              state_q    <= WAIT;
              wait_cnt_q <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            txn_count_q <= txn_count_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (go_resp) begin
        if (!in_range) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (acc_we_d) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= mem_q[idx];
          err_q   <= 1'b0;
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_count_q;

endmodule
